adc_recorder: RTL and testbench

- Record-path stage directly upstream of the playback serializer. It deserializes the codec's ADC bit stream on bclk and writes one 16-bit left-channel sample per frame into SRAM at incrementing addresses.
- The playback stage later reads those same addresses.
- Shares the SRAM address bus with the playback stage, so addr and data_out tristate when not recording.

---
 rtl/adc_recorder.sv | 164 ++++++++++++++++
 tb/tb_adc_recorder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_recorder.sv
// Record-path front end: deserializes the codec ADC stream on bclk and writes one
// left-channel sample per frame to SRAM at incrementing addresses, starting at 0 each take.
//
// state  | meaning
// IDLE   | not recording; bus released unless record is high
// ARM    | waiting for adclrc=1 so capture starts on a fresh frame edge
// SYNC   | waiting for the first left-channel bit (adclrc=0)
// SHIFT  | shifting in bits 1..DATA_W-1, LSB first
// WRITE  | one-cycle SRAM write strobe for the captured sample
// DONE   | MAX_ADDR written; holds full until record drops
module adc_recorder #(
   parameter int unsigned       ADDR_W   = 18,
   parameter int unsigned       DATA_W   = 16,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              bclk,
   input  logic              rst_n,
   input  logic              record,
   input  logic              adclrc,
   input  logic              adcdat,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_out,
   output logic              write,
   output logic              full,
   output logic [ADDR_W:0]   rec_len
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_SYNC,
      S_SHIFT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t state_q, state_nxt;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] sample_q;
   logic [CNT_W-1:0]  bit_cnt;

   logic take_start;
   logic cap_first;
   logic cap_bit;
   logic commit;
   logic wr_stb;
   logic at_max;

   assign at_max = (addr_q == MAX_ADDR);

   always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      take_start = 1'b0;
      cap_first  = 1'b0;
      cap_bit    = 1'b0;
      commit     = 1'b0;
      wr_stb     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (record) begin
               state_nxt  = S_ARM;
               take_start = 1'b1;
            end
         end
         S_ARM: begin
            if (!record) begin
               state_nxt = S_IDLE;
            end else if (adclrc) begin
               state_nxt = S_SYNC;
            end
         end
         S_SYNC: begin
            if (!record) begin
               state_nxt = S_IDLE;
            end else if (!adclrc) begin
               cap_first = 1'b1;
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // a frame edge mid-sample means the frame was short: drop it and resync
            if (!record) begin
               state_nxt = S_IDLE;
            end else if (adclrc) begin
               state_nxt = S_SYNC;
            end else begin
               cap_bit = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            wr_stb = 1'b1;
            commit = 1'b1;
            if (!record) begin
               state_nxt = S_IDLE;
            end else if (at_max) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_ARM;
            end
         end
         S_DONE: begin
            if (!record) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         sample_q <= '0;
         bit_cnt  <= '0;
         full     <= 1'b0;
         rec_len  <= '0;
      end else begin
         if (take_start) begin
            addr_q  <= '0;
            rec_len <= '0;
            full    <= 1'b0;
         end
         if (cap_first) begin
            sample_q[0] <= adcdat;
            bit_cnt     <= CNT_W'(1);
         end
         if (cap_bit) begin
            sample_q[bit_cnt] <= adcdat;
            bit_cnt           <= bit_cnt + 1'b1;
         end
         if (commit) begin
            rec_len <= rec_len + 1'b1;
            if (at_max) begin
               full <= 1'b1;
            end else begin
               addr_q <= addr_q + 1'b1;
            end
         end
      end
   end

   // write is decoded from state so an async reset drops it immediately
   assign write    = wr_stb;
   assign addr     = record ? addr_q   : {ADDR_W{1'bz}};
   assign data_out = record ? sample_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_adc_recorder.sv
// Directed bench for adc_recorder: a frame-level model is compared every cycle,
// plus literal checks of the write log, rec_len and full per scenario.
module tb_adc_recorder;
   localparam int AW = 18;
   localparam int DW = 16;

   logic bclk     = 1'b0;
   logic rst_n    = 1'b0;
   logic record   = 1'b1;
   logic record_s = 1'b0;
   logic adclrc   = 1'b1;
   logic adcdat   = 1'b0;

   tri0 [AW-1:0] addr0, addr1;
   tri0 [DW-1:0] data0, data1;
   logic         write0, write1, full0, full1;
   logic [AW:0]  len0, len1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 bclk = ~bclk;

   adc_recorder dut (
      .bclk(bclk), .rst_n(rst_n), .record(record), .adclrc(adclrc), .adcdat(adcdat),
      .addr(addr0), .data_out(data0), .write(write0), .full(full0), .rec_len(len0)
   );

   adc_recorder #(.MAX_ADDR(18'h3)) dut_s (
      .bclk(bclk), .rst_n(rst_n), .record(record_s), .adclrc(adclrc), .adcdat(adcdat),
      .addr(addr1), .data_out(data1), .write(write1), .full(full1), .rec_len(len1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- frame-level model ----------------
   logic          m_run [2];
   logic          m_halt[2];
   logic          m_hi  [2];
   logic          m_wr  [2];
   logic          m_full[2];
   int            m_nb  [2];
   logic [DW-1:0] m_smp [2];
   logic [DW-1:0] m_data[2];
   logic [AW-1:0] m_addr[2];
   logic [AW:0]   m_len [2];

   function automatic logic [AW-1:0] max_of(input int i);
      return (i == 0) ? 18'h3FFFF : 18'h3;
   endfunction

   task automatic model_reset(input int i);
      m_run[i] = 0; m_halt[i] = 0; m_hi[i] = 0; m_wr[i] = 0; m_full[i] = 0;
      m_nb[i] = 0; m_smp[i] = '0; m_data[i] = '0; m_addr[i] = '0; m_len[i] = '0;
   endtask

   task automatic model_step(input int i, input logic r, input logic l, input logic d);
      if (m_halt[i]) begin
         if (!r) m_halt[i] = 0;
      end else if (!m_run[i]) begin
         if (r) begin
            m_run[i] = 1; m_addr[i] = '0; m_len[i] = '0; m_full[i] = 0;
            m_hi[i] = 0; m_nb[i] = 0;
         end
      end else if (m_wr[i]) begin
         m_wr[i]  = 0;
         m_len[i] = m_len[i] + 1;
         if (m_addr[i] == max_of(i)) begin
            m_full[i] = 1; m_run[i] = 0; m_halt[i] = r;
         end else begin
            m_addr[i] = m_addr[i] + 1;
            m_hi[i] = 0; m_nb[i] = 0;
            if (!r) m_run[i] = 0;
         end
      end else if (!r) begin
         m_run[i] = 0;
      end else if (!m_hi[i]) begin
         if (l) m_hi[i] = 1;
      end else if (l) begin
         m_nb[i] = 0;
      end else begin
         m_smp[i][m_nb[i]] = d;
         m_nb[i]++;
         if (m_nb[i] == DW) begin
            m_wr[i] = 1; m_data[i] = m_smp[i]; m_nb[i] = 0;
         end
      end
   endtask

   always @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) model_reset(i);
      end else begin
         model_step(0, record, adclrc, adcdat);
         model_step(1, record_s, adclrc, adcdat);
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [AW-1:0] la0[$], la1[$];
   logic [DW-1:0] ld0[$], ld1[$];

   task automatic cmp(input int i, input logic wr, input logic fl, input logic [AW:0] ln,
                      input logic [AW-1:0] ad, input logic [DW-1:0] dq, input logic r);
      chk($sformatf("write%0d", i), 32'(wr), 32'(m_wr[i]));
      chk($sformatf("full%0d", i), 32'(fl), 32'(m_full[i]));
      chk($sformatf("rec_len%0d", i), 32'(ln), 32'(m_len[i]));
      if (r) begin
         chk($sformatf("addr%0d", i), 32'(ad), 32'(m_addr[i]));
         if (m_wr[i]) chk($sformatf("data%0d", i), 32'(dq), 32'(m_data[i]));
      end else begin
         chk($sformatf("addr_released%0d", i), 32'(ad), 32'h0);
         chk($sformatf("data_released%0d", i), 32'(dq), 32'h0);
      end
   endtask

   always @(negedge bclk) begin
      cmp(0, write0, full0, len0, addr0, data0, record);
      cmp(1, write1, full1, len1, addr1, data1, record_s);
      if (write0) begin la0.push_back(addr0); ld0.push_back(data0); end
      if (write1) begin la1.push_back(addr1); ld1.push_back(data1); end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic l, input logic d);
      @(posedge bclk); #2;
      adclrc = l; adcdat = d;
   endtask

   task automatic frame(input logic [DW-1:0] v, input int nb);
      repeat (3) drive(1'b1, 1'b0);
      for (int k = 0; k < nb; k++) drive(1'b0, v[k]);
   endtask

   task automatic gap(input int n);
      repeat (n) drive(1'b1, 1'b0);
   endtask

   task automatic clear_logs();
      la0.delete(); ld0.delete(); la1.delete(); ld1.delete();
   endtask

   logic [DW-1:0] stream_v[4];
   logic [DW-1:0] full_v[6];

   initial begin
      stream_v = '{16'hA5A5, 16'h0001, 16'hFFFF, 16'h1234};
      full_v   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

      // reset held with record high
      repeat (3) @(posedge bclk);
      @(negedge bclk); #1;
      chk("rst_write", 32'(write0), 32'h0);
      chk("rst_full", 32'(full0), 32'h0);
      chk("rst_rec_len", 32'(len0), 32'h0);
      @(posedge bclk); #2;
      record = 1'b0; rst_n = 1'b1;
      @(negedge bclk); #1;
      chk("rst_addr_released", 32'(addr0), 32'h0);
      chk("rst_data_released", 32'(data0), 32'h0);

      // single sample
      clear_logs();
      @(posedge bclk); #2; record = 1'b1;
      frame(16'h800D, 16);
      gap(4);
      #1;
      chk("single_count", 32'(la0.size()), 32'd1);
      if (la0.size() >= 1) begin
         chk("single_addr", 32'(la0[0]), 32'h0);
         chk("single_data", 32'(ld0[0]), 32'h800D);
      end
      chk("single_rec_len", 32'(len0), 32'd1);
      record = 1'b0;
      gap(2);

      // streaming four frames
      clear_logs();
      record = 1'b1;
      for (int f = 0; f < 4; f++) frame(stream_v[f], 16);
      gap(4);
      #1;
      chk("stream_count", 32'(la0.size()), 32'd4);
      for (int f = 0; f < 4 && f < la0.size(); f++) begin
         chk($sformatf("stream_addr%0d", f), 32'(la0[f]), 32'(f));
         chk($sformatf("stream_data%0d", f), 32'(ld0[f]), 32'(stream_v[f]));
      end
      chk("stream_rec_len", 32'(len0), 32'd4);
      record = 1'b0;
      gap(3);

      // short frame then a full one
      clear_logs();
      record = 1'b1;
      frame(16'hFFFF, 10);
      frame(16'h5A3C, 16);
      gap(4);
      #1;
      chk("short_count", 32'(la0.size()), 32'd1);
      if (la0.size() >= 1) begin
         chk("short_addr", 32'(la0[0]), 32'h0);
         chk("short_data", 32'(ld0[0]), 32'h5A3C);
      end
      chk("short_rec_len", 32'(len0), 32'd1);
      record = 1'b0;
      gap(2);

      // stop mid-sample, then re-arm
      clear_logs();
      record = 1'b1;
      frame(16'h00FF, 8);
      @(posedge bclk); #2; record = 1'b0;
      gap(3);
      @(negedge bclk); #1;
      chk("stop_addr_released", 32'(addr0), 32'h0);
      chk("stop_count", 32'(la0.size()), 32'd0);
      @(posedge bclk); #2; record = 1'b1;
      frame(16'hC3A1, 16);
      gap(4);
      #1;
      chk("rearm_count", 32'(la0.size()), 32'd1);
      if (la0.size() >= 1) begin
         chk("rearm_addr", 32'(la0[0]), 32'h0);
         chk("rearm_data", 32'(ld0[0]), 32'hC3A1);
      end
      chk("rearm_rec_len", 32'(len0), 32'd1);
      record = 1'b0;
      gap(2);

      // memory full on the small instance
      clear_logs();
      record_s = 1'b1;
      for (int f = 0; f < 6; f++) frame(full_v[f], 16);
      gap(4);
      #1;
      chk("full_count", 32'(la1.size()), 32'd4);
      for (int f = 0; f < 4 && f < la1.size(); f++) begin
         chk($sformatf("full_addr%0d", f), 32'(la1[f]), 32'(f));
         chk($sformatf("full_data%0d", f), 32'(ld1[f]), 32'(full_v[f]));
      end
      chk("full_flag", 32'(full1), 32'h1);
      chk("full_rec_len", 32'(len1), 32'd4);
      record_s = 1'b0;
      gap(3);
      #1;
      chk("full_kept", 32'(full1), 32'h1);
      chk("full_len_kept", 32'(len1), 32'd4);
      chk("full_no_more", 32'(la1.size()), 32'd4);

      // async reset during the write cycle
      record = 1'b1;
      frame(16'h1357, 16);
      begin
         bit seen = 1'b0;
         for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge bclk);
            if (write0) seen = 1'b1;
         end
         chk("midwrite_reached", 32'(seen), 32'h1);
         #1 rst_n = 1'b0;
         #1 chk("midwrite_rst_write", 32'(write0), 32'h0);
         chk("midwrite_rst_len", 32'(len0), 32'h0);
      end
      @(posedge bclk); #2;
      record = 1'b0; rst_n = 1'b1;
      gap(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
